// File: rtl/afu_host_rx_split_if.sv
// rtl/afu_host_rx_split_if.sv - AXI-Stream-like beat bundle for the host RX splitter ports
interface afu_host_rx_split_if #(
  parameter int TDATA_W = 512,
  parameter int TUSER_W = 10
);
  logic                 tvalid;
  logic                 tready;
  logic [TDATA_W-1:0]   tdata;
  logic [TDATA_W/8-1:0] tkeep;
  logic                 tlast;
  logic [TUSER_W-1:0]   tuser_vendor;

  modport master (
    output tvalid, tdata, tkeep, tlast, tuser_vendor,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast, tuser_vendor,
    output tready
  );
endinterface

// File: rtl/afu_host_rx_split.sv
// rtl/afu_host_rx_split.sv - splits host RX into completion (cpl) and request (req) streams, packet-aware
// Optional per-output packet counters under `define RX_SPLIT_STATS_EN.
module afu_host_rx_split_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         not_full,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   count_nxt;
  logic         rd_en;

  assign rd_en     = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = rd_ptr ? slot1 : slot0;

  always_comb begin
    count_nxt = count;
    if (wr_en && !rd_en) begin
      count_nxt = count + 2'd1;
    end else if (!wr_en && rd_en) begin
      count_nxt = count - 2'd1;
    end
  end

  // not_full is registered from the next occupancy so upstream ready never sees out_ready combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      not_full <= 1'b1;
    end else begin
      count    <= count_nxt;
      not_full <= (count_nxt != 2'd2);
      if (wr_en) begin
        wr_ptr <= ~wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !wr_ptr) begin
      slot0 <= wr_data;
    end
    if (wr_en && wr_ptr) begin
      slot1 <= wr_data;
    end
  end
endmodule

module afu_host_rx_split #(
  parameter int TDATA_W = 512,
  parameter int TUSER_W = 10,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  afu_host_rx_split_if.slave  rx,
  afu_host_rx_split_if.master cpl,
  afu_host_rx_split_if.master req,
  output logic [CNT_W-1:0]   cpl_pkt_cnt,
  output logic [CNT_W-1:0]   req_pkt_cnt
);
  localparam int KEEP_W = TDATA_W / 8;
  localparam int BEAT_W = TUSER_W + 1 + KEEP_W + TDATA_W;

  logic              is_sop;
  logic              route_q;
  logic              is_cpl;
  logic              sel;
  logic              in_hs;
  logic              cpl_not_full;
  logic              req_not_full;
  logic [BEAT_W-1:0] rx_beat;
  logic [BEAT_W-1:0] cpl_beat;
  logic [BEAT_W-1:0] req_beat;

  // Cpl and CplD share type 01010 in both PU and DM header encodings; anything else goes to req
  always_comb begin
    is_cpl = 1'b0;
    if (rx.tdata[28:24] == 5'b01010) begin
      is_cpl = 1'b1;
    end
  end

  assign sel       = is_sop ? is_cpl : route_q;
  assign rx.tready = !rst && (sel ? cpl_not_full : req_not_full);
  assign in_hs     = rx.tvalid && rx.tready;
  assign rx_beat   = {rx.tuser_vendor, rx.tlast, rx.tkeep, rx.tdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      is_sop  <= 1'b1;
      route_q <= 1'b1;
    end else if (in_hs) begin
      is_sop  <= rx.tlast;
      route_q <= sel;
    end
  end

  afu_host_rx_split_skid #(.W(BEAT_W)) u_cpl_skid (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (in_hs && sel),
    .wr_data   (rx_beat),
    .not_full  (cpl_not_full),
    .out_valid (cpl.tvalid),
    .out_ready (cpl.tready),
    .out_data  (cpl_beat)
  );

  afu_host_rx_split_skid #(.W(BEAT_W)) u_req_skid (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (in_hs && !sel),
    .wr_data   (rx_beat),
    .not_full  (req_not_full),
    .out_valid (req.tvalid),
    .out_ready (req.tready),
    .out_data  (req_beat)
  );

  assign {cpl.tuser_vendor, cpl.tlast, cpl.tkeep, cpl.tdata} = cpl_beat;
  assign {req.tuser_vendor, req.tlast, req.tkeep, req.tdata} = req_beat;

`ifdef RX_SPLIT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cpl_pkt_cnt <= '0;
      req_pkt_cnt <= '0;
    end else begin
      if (cpl.tvalid && cpl.tready && cpl.tlast) begin
        cpl_pkt_cnt <= cpl_pkt_cnt + CNT_W'(1);
      end
      if (req.tvalid && req.tready && req.tlast) begin
        req_pkt_cnt <= req_pkt_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign cpl_pkt_cnt = '0;
  assign req_pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_afu_host_rx_split.sv
// tb/tb_afu_host_rx_split.sv - directed bench with a queue-based reference model for afu_host_rx_split
module tb_afu_host_rx_split;
  localparam int TDATA_W = 512;
  localparam int TUSER_W = 10;
  localparam int CNT_W   = 4;
  localparam int KEEP_W  = TDATA_W / 8;
`ifdef RX_SPLIT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [TDATA_W-1:0] data;
    logic [KEEP_W-1:0]  keep;
    logic               last;
    logic [TUSER_W-1:0] user;
  } beat_t;

  typedef struct {
    logic [7:0] ft;
    int         len;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CNT_W-1:0] cpl_pkt_cnt;
  logic [CNT_W-1:0] req_pkt_cnt;

  always #5 clk = ~clk;

  afu_host_rx_split_if #(.TDATA_W(TDATA_W), .TUSER_W(TUSER_W)) rx_if ();
  afu_host_rx_split_if #(.TDATA_W(TDATA_W), .TUSER_W(TUSER_W)) cpl_if ();
  afu_host_rx_split_if #(.TDATA_W(TDATA_W), .TUSER_W(TUSER_W)) req_if ();

  afu_host_rx_split #(.TDATA_W(TDATA_W), .TUSER_W(TUSER_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx_if),
    .cpl         (cpl_if),
    .req         (req_if),
    .cpl_pkt_cnt (cpl_pkt_cnt),
    .req_pkt_cnt (req_pkt_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_data(input string name, input logic [TDATA_W-1:0] act, input logic [TDATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each output buffer is the list of beats accepted for it and not yet delivered
  beat_t cpl_q[$];
  beat_t req_q[$];
  bit    model_on = 1'b0;
  bit    m_sop;
  bit    m_route;
  logic [CNT_W-1:0] m_cpl_cnt;
  logic [CNT_W-1:0] m_req_cnt;
  int    cpl_deliv = 0;
  int    req_deliv = 0;
  int    last_cpl_cyc = 0;
  int    last_req_cyc = 0;
  bit    exp_sel, exp_rdy, in_hs, cpl_hs, req_hs;
  beat_t eb, nb, blank;

  task automatic check_port(input string name, input logic vld, input logic [TDATA_W-1:0] d,
                            input logic [KEEP_W-1:0] k, input logic l, input logic [TUSER_W-1:0] u,
                            input bit has, input beat_t e);
    chk({name, "_tvalid"}, longint'(vld), longint'(has));
    if (has) begin
      chk_data({name, "_tdata"}, d, e.data);
      chk({name, "_tkeep"}, longint'(k), longint'(e.keep));
      chk({name, "_tlast"}, longint'(l), longint'(e.last));
      chk({name, "_tuser"}, longint'(u), longint'(e.user));
    end
  endtask

  always @(negedge clk) begin
    exp_sel = m_sop ? (rx_if.tdata[28:24] == 5'b01010) : m_route;
    exp_rdy = !rst && (exp_sel ? (cpl_q.size() < 2) : (req_q.size() < 2));
    in_hs  = 1'b0;
    cpl_hs = 1'b0;
    req_hs = 1'b0;
    if (model_on) begin
      chk("rx_tready", longint'(rx_if.tready), longint'(exp_rdy));
      eb = blank;
      if (cpl_q.size() != 0) eb = cpl_q[0];
      check_port("cpl", cpl_if.tvalid, cpl_if.tdata, cpl_if.tkeep, cpl_if.tlast, cpl_if.tuser_vendor,
                 cpl_q.size() != 0, eb);
      eb = blank;
      if (req_q.size() != 0) eb = req_q[0];
      check_port("req", req_if.tvalid, req_if.tdata, req_if.tkeep, req_if.tlast, req_if.tuser_vendor,
                 req_q.size() != 0, eb);
      chk("cpl_pkt_cnt", longint'(cpl_pkt_cnt), longint'(STATS ? m_cpl_cnt : '0));
      chk("req_pkt_cnt", longint'(req_pkt_cnt), longint'(STATS ? m_req_cnt : '0));
      in_hs  = rx_if.tvalid && exp_rdy;
      cpl_hs = (cpl_q.size() != 0) && cpl_if.tready;
      req_hs = (req_q.size() != 0) && req_if.tready;
    end
    if (rst) begin
      cpl_q.delete();
      req_q.delete();
      m_sop     = 1'b1;
      m_route   = 1'b1;
      m_cpl_cnt = '0;
      m_req_cnt = '0;
      model_on  = 1'b1;
    end else if (model_on) begin
      if (cpl_hs) begin
        eb = cpl_q.pop_front();
        cpl_deliv++;
        last_cpl_cyc = cyc + 1;
        if (eb.last) m_cpl_cnt = m_cpl_cnt + 1'b1;
      end
      if (req_hs) begin
        eb = req_q.pop_front();
        req_deliv++;
        last_req_cyc = cyc + 1;
        if (eb.last) m_req_cnt = m_req_cnt + 1'b1;
      end
      if (in_hs) begin
        nb.data = rx_if.tdata;
        nb.keep = rx_if.tkeep;
        nb.last = rx_if.tlast;
        nb.user = rx_if.tuser_vendor;
        if (exp_sel) cpl_q.push_back(nb);
        else req_q.push_back(nb);
        m_sop   = rx_if.tlast;
        m_route = exp_sel;
      end
    end
  end

  function automatic logic [TDATA_W-1:0] mk_data(input logic [7:0] ft, input int tag);
    logic [TDATA_W-1:0] d;
    d = {(TDATA_W/32){32'(tag)}};
    d[31:24] = ft;
    return d;
  endfunction

  int hs_cyc = 0;

  task automatic offer(input logic [7:0] ft, input bit last, input int tag, input int max_cyc, output bit ok);
    rx_if.tvalid       = 1'b1;
    rx_if.tdata        = mk_data(ft, tag);
    rx_if.tkeep        = {2{32'(tag) ^ 32'h5A5A_0F0F}};
    rx_if.tlast        = last;
    rx_if.tuser_vendor = TUSER_W'(tag);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      ok = rx_if.tready;
      @(posedge clk);
      #1;
    end
    hs_cyc = cyc;
  endtask

  task automatic send(input logic [7:0] ft, input bit last, input int tag);
    bit ok;
    offer(ft, last, tag, 50, ok);
    chk("send_handshake", longint'(ok), 1);
  endtask

  task automatic idle(input int n);
    rx_if.tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  pkt_t pkts[6] = '{'{8'h4A, 1}, '{8'h20, 3}, '{8'h30, 1}, '{8'h0A, 2}, '{8'h60, 2}, '{8'h4A, 4}};
  bit   t7_done = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c0, r0, h1, h2;
    rx_if.tvalid = 1'b0;
    rx_if.tdata = '0;
    rx_if.tkeep = '0;
    rx_if.tlast = 1'b0;
    rx_if.tuser_vendor = '0;
    cpl_if.tready = 1'b0;
    req_if.tready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_tready", longint'(rx_if.tready), 0);
    chk("reset_cpl_tvalid", longint'(cpl_if.tvalid), 0);
    rst = 1'b0;
    idle(2);

    // 3-beat CplD, both outputs ready; data beats carry MRd-looking bits that must not re-route
    cpl_if.tready = 1'b1;
    req_if.tready = 1'b1;
    c0 = cpl_deliv;
    r0 = req_deliv;
    send(8'h4A, 1'b0, 'h100);
    send(8'h00, 1'b0, 'h101);
    send(8'h20, 1'b1, 'h102);
    h1 = hs_cyc;
    idle(3);
    chk("t1_cpl_beats", cpl_deliv - c0, 3);
    chk("t1_req_beats", req_deliv - r0, 0);
    chk("t1_latency", last_cpl_cyc, h1 + 1);

    // MWr then CplD back to back
    send(8'h60, 1'b1, 'h200);
    h1 = hs_cyc;
    send(8'h4A, 1'b1, 'h201);
    h2 = hs_cyc;
    idle(3);
    chk("t2_no_bubble", h2, h1 + 1);
    chk("t2_req_at_t1", last_req_cyc, h1 + 1);
    chk("t2_cpl_at_t2", last_cpl_cyc, h1 + 2);

    // req stalled: 2 of 3 MRd beats accepted, third blocked until release
    req_if.tready = 1'b0;
    r0 = req_deliv;
    send(8'h20, 1'b0, 'h300);
    send(8'h4A, 1'b0, 'h301);
    offer(8'h4A, 1'b1, 'h302, 8, ok);
    chk("t3_third_blocked", longint'(ok), 0);
    chk("t3_rx_tready_low", longint'(rx_if.tready), 0);
    req_if.tready = 1'b1;
    offer(8'h4A, 1'b1, 'h302, 20, ok);
    chk("t3_third_accepted", longint'(ok), 1);
    idle(4);
    chk("t3_req_beats", req_deliv - r0, 3);

    // req full, cpl full; cpl still drains while the input waits on req
    cpl_if.tready = 1'b0;
    req_if.tready = 1'b0;
    send(8'h4A, 1'b0, 'h400);
    send(8'h00, 1'b1, 'h401);
    send(8'h20, 1'b1, 'h402);
    send(8'h30, 1'b1, 'h403);
    offer(8'h20, 1'b1, 'h404, 4, ok);
    chk("t4_blocked", longint'(ok), 0);
    c0 = cpl_deliv;
    cpl_if.tready = 1'b1;
    offer(8'h20, 1'b1, 'h404, 4, ok);
    chk("t4_still_blocked", longint'(ok), 0);
    chk("t4_cpl_drained", cpl_deliv - c0, 2);
    req_if.tready = 1'b1;
    offer(8'h20, 1'b1, 'h404, 20, ok);
    chk("t4_req_freed", longint'(ok), 1);
    idle(4);

    // reset on beat 2 of a 4-beat CplD
    cpl_if.tready = 1'b0;
    send(8'h4A, 1'b0, 'h500);
    rx_if.tdata = mk_data(8'h00, 'h501);
    rx_if.tlast = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_if.tvalid = 1'b0;
    chk("t5_cpl_tvalid", longint'(cpl_if.tvalid), 0);
    chk("t5_req_tvalid", longint'(req_if.tvalid), 0);
    chk("t5_cpl_cnt", longint'(cpl_pkt_cnt), 0);
    chk("t5_req_cnt", longint'(req_pkt_cnt), 0);
    cpl_if.tready = 1'b1;
    c0 = cpl_deliv;
    r0 = req_deliv;
    send(8'h20, 1'b1, 'h502);
    idle(3);
    chk("t5_mrd_to_req", req_deliv - r0, 1);
    chk("t5_nothing_on_cpl", cpl_deliv - c0, 0);

    // 17 single-beat completions: 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      send(8'h4A, 1'b1, 'h600 + i);
    end
    idle(3);
    chk("t6_cpl_cnt_wrap", longint'(cpl_pkt_cnt), STATS ? 1 : 0);
    chk("t6_req_cnt", longint'(req_pkt_cnt), STATS ? 1 : 0);

    // mixed traffic under random output backpressure
    fork
      begin
        for (int p = 0; p < 6; p++) begin
          for (int b = 0; b < pkts[p].len; b++) begin
            send((b == 0) ? pkts[p].ft : 8'h4A, (b == pkts[p].len - 1), 'h700 + p * 16 + b);
          end
        end
        t7_done = 1'b1;
      end
      begin
        while (!t7_done) begin
          @(posedge clk);
          #1;
          cpl_if.tready = 1'($urandom_range(0, 1));
          req_if.tready = 1'($urandom_range(0, 1));
        end
      end
    join
    cpl_if.tready = 1'b1;
    req_if.tready = 1'b1;
    idle(10);
    chk("t7_cpl_drained", cpl_q.size(), 0);
    chk("t7_req_drained", req_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
